// File: rtl/inputlogic_if.sv
// Pixel stream and held-vector bus between the upstream word source, the deserialiser and the
// projection datapath. The master drives words and consume; the slave presents the assembled vector.
interface inputlogic_if #(
    parameter int NUM_PIXELS = 160
);
    logic                        in_valid;
    logic [31:0]                 in_data;
    logic                        in_ready;
    logic                        consume;
    logic [NUM_PIXELS-1:0][31:0] pix_out;
    logic                        vec_valid;

    modport master (
        output in_valid,
        output in_data,
        output consume,
        input  in_ready,
        input  pix_out,
        input  vec_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  consume,
        output in_ready,
        output pix_out,
        output vec_valid
    );
endinterface

// File: rtl/inputlogic.sv
// Serial-to-parallel pixel loader: fills a NUM_PIXELS x 32 bank one word per accept, holds each
// complete sample until the datapath consumes it, and flags done after the last sample.
module inputlogic #(
    parameter int NUM_PIXELS  = 160,
    parameter int NUM_SAMPLES = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    inputlogic_if.slave bus,
    output logic [8:0]  pixel_iter,
    output logic [8:0]  sample_iter,
    output logic        done
);

    localparam logic [8:0] LAST_PIX    = 9'(NUM_PIXELS - 1);
    localparam logic [8:0] LAST_SAMPLE = 9'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_reg;
    logic [8:0] pixel_iter_reg;
    logic [8:0] sample_iter_reg;
    logic       vec_valid_reg;
    logic       done_reg;

    logic       flush;
    logic       load_ready;
    logic       accept;

    // clear behaves exactly like reset for every register in the block
    assign flush      = !rst_n || clear;
    assign load_ready = (state_reg == LOAD);
    assign accept     = bus.in_valid && load_ready;

    always_ff @(posedge clk) begin
        if (flush) begin
            state_reg       <= IDLE;
            pixel_iter_reg  <= 9'd0;
            sample_iter_reg <= 9'd0;
            vec_valid_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg       <= LOAD;
                        pixel_iter_reg  <= 9'd0;
                        sample_iter_reg <= 9'd0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (pixel_iter_reg == LAST_PIX) begin
                            pixel_iter_reg <= 9'd0;
                            vec_valid_reg  <= 1'b1;
                            state_reg      <= HOLD;
                        end else begin
                            pixel_iter_reg <= pixel_iter_reg + 9'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.consume) begin
                        vec_valid_reg <= 1'b0;
                        if (sample_iter_reg == LAST_SAMPLE) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            sample_iter_reg <= sample_iter_reg + 9'd1;
                            state_reg       <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // One register per bank word; only the word addressed by pixel_iter loads on an accept,
    // so words not yet rewritten keep the previous sample's contents.
    generate
        for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_bank
            logic [31:0] word_reg;

            always_ff @(posedge clk) begin
                if (flush) begin
                    word_reg <= 32'd0;
                end else if (accept && (pixel_iter_reg == 9'(gi))) begin
                    word_reg <= bus.in_data;
                end
            end

            assign bus.pix_out[gi] = word_reg;
        end
    endgenerate

    assign bus.in_ready  = load_ready;
    assign bus.vec_valid = vec_valid_reg;
    assign pixel_iter    = pixel_iter_reg;
    assign sample_iter   = sample_iter_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_inputlogic.sv
// Bench for inputlogic: a small 4x2 instance for directed sequences and a default 160x400 instance
// for a full random run; held vectors are checked by a scoreboard monitor.
module tb_inputlogic;

    localparam int SP = 4;
    localparam int SS = 2;
    localparam int BP = 160;
    localparam int BS = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s_start, s_clear, b_start, b_clear;
    logic [8:0] s_piter, s_siter, b_piter, b_siter;
    logic       s_done, b_done;

    inputlogic_if #(.NUM_PIXELS(SP)) s_bus ();
    inputlogic_if #(.NUM_PIXELS(BP)) b_bus ();

    inputlogic #(.NUM_PIXELS(SP), .NUM_SAMPLES(SS)) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (s_start),
        .clear       (s_clear),
        .bus         (s_bus.slave),
        .pixel_iter  (s_piter),
        .sample_iter (s_siter),
        .done        (s_done)
    );

    inputlogic #(.NUM_PIXELS(BP), .NUM_SAMPLES(BS)) u_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (b_start),
        .clear       (b_clear),
        .bus         (b_bus.slave),
        .pixel_iter  (b_piter),
        .sample_iter (b_siter),
        .done        (b_done)
    );

    int checks = 0;
    int errors = 0;

    logic [SP*32-1:0] s_exp_q[$];
    logic [BP*32-1:0] b_exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SP*32-1:0] sv4(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic s_feed(input logic [31:0] w);
        s_bus.in_valid = 1'b1;
        s_bus.in_data  = w;
        tick();
    endtask

    task automatic s_consume();
        s_bus.consume = 1'b1;
        tick();
        s_bus.consume = 1'b0;
    endtask

    // Scoreboard monitors: each rising vec_valid presents one vector to compare.
    logic             s_vv_prev = 1'b0;
    logic             b_vv_prev = 1'b0;
    int               s_vec_n   = 0;
    int               b_vec_n   = 0;
    logic [SP*32-1:0] s_exp;
    logic [BP*32-1:0] b_exp;
    logic [BP*32-1:0] b_act;

    always @(negedge clk) begin
        if (s_bus.vec_valid && !s_vv_prev) begin
            checks++;
            if (s_exp_q.size() == 0) begin
                errors++;
                $display("FAIL small_vec: vector %0d presented with nothing expected", s_vec_n);
            end else begin
                s_exp = s_exp_q.pop_front();
                if (s_bus.pix_out !== s_exp) begin
                    errors++;
                    $display("FAIL small_vec: vector %0d got %0h expected %0h", s_vec_n, s_bus.pix_out, s_exp);
                end else begin
                    $display("small vector %0d = %0h", s_vec_n, s_exp);
                end
            end
            s_vec_n++;
        end
        s_vv_prev = s_bus.vec_valid;
    end

    always @(negedge clk) begin
        if (b_bus.vec_valid && !b_vv_prev) begin
            checks++;
            if (b_exp_q.size() == 0) begin
                errors++;
                $display("FAIL big_vec: vector %0d presented with nothing expected", b_vec_n);
            end else begin
                b_exp = b_exp_q.pop_front();
                b_act = b_bus.pix_out;
                if (b_act !== b_exp) begin
                    errors++;
                    for (int i = 0; i < BP; i++) begin
                        if (b_act[i*32 +: 32] !== b_exp[i*32 +: 32]) begin
                            $display("FAIL big_vec: vector %0d word %0d got %0h expected %0h",
                                     b_vec_n, i, b_act[i*32 +: 32], b_exp[i*32 +: 32]);
                            break;
                        end
                    end
                end else begin
                    $display("big vector %0d matched", b_vec_n);
                end
            end
            b_vec_n++;
        end
        b_vv_prev = b_bus.vec_valid;
    end

    initial begin
        logic [BP*32-1:0] vec;

        rst_n = 1'b0;
        s_start = 1'b1;
        s_clear = 1'b0;
        b_start = 1'b1;
        b_clear = 1'b0;
        s_bus.in_valid = 1'b0;
        s_bus.in_data  = 32'd0;
        s_bus.consume  = 1'b0;
        b_bus.in_valid = 1'b0;
        b_bus.in_data  = 32'd0;
        b_bus.consume  = 1'b0;

        // 1: reset held two cycles while start is asserted
        tick();
        tick();
        chk("rst_in_ready", s_bus.in_ready, 0);
        chk("rst_vec_valid", s_bus.vec_valid, 0);
        chk("rst_done", s_done, 0);
        chk("rst_piter", s_piter, 0);
        chk("rst_siter", s_siter, 0);
        chk("rst_pix_out", s_bus.pix_out, 0);
        chk("rst_big_in_ready", b_bus.in_ready, 0);
        rst_n = 1'b1;
        s_start = 1'b0;
        b_start = 1'b0;
        tick();
        chk("idle_after_rst", s_bus.in_ready, 0);

        // 2: full run, in_valid always high
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("load_in_ready", s_bus.in_ready, 1);
        s_exp_q.push_back(sv4(32'h10));
        s_feed(32'h10);
        chk("piter_after_1", s_piter, 1);
        s_feed(32'h11);
        s_feed(32'h12);
        chk("vv_before_last", s_bus.vec_valid, 0);
        s_feed(32'h13);
        chk("vv_after_last", s_bus.vec_valid, 1);
        chk("hold_in_ready", s_bus.in_ready, 0);
        chk("piter_wrap", s_piter, 0);
        s_consume();
        chk("vv_after_consume", s_bus.vec_valid, 0);
        chk("siter_1", s_siter, 1);
        s_exp_q.push_back(sv4(32'h20));
        s_feed(32'h20);
        s_feed(32'h21);
        s_feed(32'h22);
        s_feed(32'h23);
        chk("done_before_consume", s_done, 0);
        s_consume();
        chk("done_after_consume", s_done, 1);
        chk("done_in_ready", s_bus.in_ready, 0);
        chk("done_siter", s_siter, 1);
        s_bus.in_valid = 1'b0;

        // 3: gaps between words, then a long hold with in_valid high
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        chk("clear_done", s_done, 0);
        chk("clear_pix_out", s_bus.pix_out, 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_exp_q.push_back(sv4(32'h30));
        for (int k = 0; k < SP; k++) begin
            s_feed(32'h30 + 32'(k));
            s_bus.in_valid = 1'b0;
            s_bus.in_data  = 32'hDEAD_0000;
            tick();
            tick();
            if (k < SP - 1) chk("gap_piter", s_piter, 128'(k + 1));
        end
        s_bus.in_valid = 1'b1;
        s_bus.in_data  = 32'hBAD0_BAD0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_no_ready", s_bus.in_ready, 0);
        end
        chk("hold_stable", s_bus.pix_out, sv4(32'h30));
        chk("hold_vv", s_bus.vec_valid, 1);
        s_consume();
        chk("gap_siter", s_siter, 1);

        // 4: clear after two words of a sample
        s_feed(32'h40);
        s_feed(32'h41);
        chk("partial_piter", s_piter, 2);
        s_clear = 1'b1;
        s_bus.in_data = 32'h99;
        tick();
        s_clear = 1'b0;
        s_bus.in_valid = 1'b0;
        chk("abort_piter", s_piter, 0);
        chk("abort_siter", s_siter, 0);
        chk("abort_pix_out", s_bus.pix_out, 0);
        chk("abort_in_ready", s_bus.in_ready, 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_exp_q.push_back(sv4(32'h50));
        s_feed(32'h50);
        s_feed(32'h51);
        s_feed(32'h52);
        s_feed(32'h53);
        chk("restart_vv", s_bus.vec_valid, 1);

        // 5: simultaneous controls and ignored inputs
        s_bus.in_valid = 1'b0;
        s_clear = 1'b1;
        s_start = 1'b1;
        tick();
        tick();
        s_clear = 1'b0;
        s_start = 1'b0;
        chk("clear_start_idle", s_bus.in_ready, 0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_bus.consume = 1'b1;
        tick();
        s_bus.consume = 1'b0;
        chk("consume_load_ready", s_bus.in_ready, 1);
        chk("consume_load_siter", s_siter, 0);
        s_exp_q.push_back(sv4(32'h60));
        s_feed(32'h60);
        s_feed(32'h61);
        s_feed(32'h62);
        s_feed(32'h63);
        s_consume();
        s_exp_q.push_back(sv4(32'h70));
        s_feed(32'h70);
        s_feed(32'h71);
        s_feed(32'h72);
        s_feed(32'h73);
        s_bus.in_valid = 1'b0;
        s_consume();
        chk("sim_done", s_done, 1);
        s_start = 1'b1;
        tick();
        tick();
        s_start = 1'b0;
        chk("start_in_done", s_done, 1);
        chk("start_in_done_ready", s_bus.in_ready, 0);
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        chk("done_cleared", s_done, 0);

        // 6: default-size run with random words
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int s = 0; s < BS; s++) begin
            for (int p = 0; p < BP; p++) vec[p*32 +: 32] = $urandom;
            b_exp_q.push_back(vec);
            for (int p = 0; p < BP; p++) begin
                b_bus.in_valid = 1'b1;
                b_bus.in_data  = vec[p*32 +: 32];
                tick();
            end
            b_bus.in_valid = 1'b0;
            if (s == BS - 1) chk("big_done_before", b_done, 0);
            b_bus.consume = 1'b1;
            tick();
            b_bus.consume = 1'b0;
        end
        chk("big_done", b_done, 1);
        chk("big_vv", b_bus.vec_valid, 0);
        chk("big_siter", b_siter, 128'(BS - 1));
        chk("big_piter", b_piter, 0);

        tick();
        chk("small_queue_empty", 128'(s_exp_q.size()), 0);
        chk("big_queue_empty", 128'(b_exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
